// File: rtl/fpga_cfg_pkg.sv
// Shared types and default sizing for the CRAM configuration loader and the fabric top.
package fpga_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } cfg_state_t;

    localparam int CFG_WORD_W    = 32;
    localparam int CFG_CHAIN_LEN = 2048;

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Host word stream into the configuration loader (valid/ready, bit 0 shifted first).
interface fpga_cfg_loader_if #(
    parameter int WORD_W = 32
);
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;

    modport master (output word_valid, output word_data, input  word_ready);
    modport slave  (input  word_valid, input  word_data, output word_ready);
endinterface

// File: rtl/cfg_word_serializer.sv
// Parallel-load LSB-first shift register with per-word bit counter.
// With CFG_READBACK_EN defined it also captures the chain's outgoing bits into rb_data_o.
module cfg_word_serializer #(
    parameter int WORD_W = 32,
    parameter int KW     = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [KW-1:0]     k_i,
`ifdef CFG_READBACK_EN
    input  logic              sdi_i,
    output logic              rb_valid_o,
    output logic [WORD_W-1:0] rb_data_o,
`endif
    output logic              sdo_o,
    output logic              last_bit_o
);
    logic [WORD_W-1:0] sreg_q;
    logic [KW-1:0]     cnt_q;
    logic [KW-1:0]     k_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            k_q    <= '0;
        end else if (load_i) begin
            sreg_q <= data_i;
            cnt_q  <= '0;
            k_q    <= k_i;
        end else if (shift_i) begin
            sreg_q <= sreg_q >> 1;
            cnt_q  <= cnt_q + KW'(1);
        end
    end

    assign sdo_o      = sreg_q[0];
    assign last_bit_o = (cnt_q == k_q - KW'(1));

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] cap_q;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;

    // Capture is cleared per word so bits at and above k read back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (load_i) begin
                cap_q <= '0;
            end else if (shift_i) begin
                cap_q <= cap_q | (WORD_W'(sdi_i) << cnt_q);
                if (last_bit_o) begin
                    rb_data_q  <= cap_q | (WORD_W'(sdi_i) << cnt_q);
                    rb_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rb_valid_o = rb_valid_q;
    assign rb_data_o  = rb_data_q;
`endif

endmodule

// File: rtl/fpga_cfg_loader.sv
// CRAM scan-chain loader: takes host words and shifts exactly CHAIN_LEN bits per load.
// Define CFG_READBACK_EN to add rb_valid/rb_data readback of the bits leaving the chain.
//
// state | meaning
// IDLE  | waiting for start, chain untouched
// LOAD  | word_ready high, waiting for a host word
// SHIFT | one chain bit per cycle, cfg_en high
// DONE  | one-cycle done pulse
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W    = CFG_WORD_W,
    parameter int CHAIN_LEN = CFG_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    fpga_cfg_loader_if.slave  host,
    output logic              cfg_en,
    output logic              cfg_sdo,
    input  logic              cfg_sdi,
    output logic              busy,
    output logic              done,
`ifdef CFG_READBACK_EN
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
`endif
    output logic [CNT_W-1:0]  bits_left
);
    localparam int KW = $clog2(WORD_W + 1);

    cfg_state_t       state_q;
    logic [CNT_W-1:0] bits_left_q;
    logic             cfg_en_q;
    logic             word_ready_q;
    logic             busy_q;
    logic             done_q;
    logic [KW-1:0]    word_k;
    int unsigned      bits_left_int;
    logic             load;
    logic             last_bit;
    logic             sreg_bit;

    // Compare in 32 bits so a chain shorter than one word still clamps correctly.
    always_comb begin
        bits_left_int = 32'(bits_left_q);
        word_k        = (bits_left_int >= WORD_W) ? KW'(WORD_W) : KW'(bits_left_int);
    end

    assign load = word_ready_q && host.word_valid;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q      <= IDLE;
            bits_left_q  <= '0;
            cfg_en_q     <= 1'b0;
            word_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= LOAD;
                        bits_left_q  <= CNT_W'(CHAIN_LEN);
                        word_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (host.word_valid) begin
                        state_q      <= SHIFT;
                        word_ready_q <= 1'b0;
                        cfg_en_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    bits_left_q <= bits_left_q - CNT_W'(1);
                    if (last_bit) begin
                        cfg_en_q <= 1'b0;
                        if (bits_left_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= LOAD;
                            word_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    cfg_word_serializer #(
        .WORD_W (WORD_W),
        .KW     (KW)
    ) u_ser (
        .clk        (clk),
        .rst        (rst || abort),
        .load_i     (load),
        .shift_i    (cfg_en_q),
        .data_i     (host.word_data),
        .k_i        (word_k),
`ifdef CFG_READBACK_EN
        .sdi_i      (cfg_sdi),
        .rb_valid_o (rb_valid),
        .rb_data_o  (rb_data),
`endif
        .sdo_o      (sreg_bit),
        .last_bit_o (last_bit)
    );

`ifndef CFG_READBACK_EN
    logic unused_cfg_sdi;
    assign unused_cfg_sdi = cfg_sdi;
`endif

    assign host.word_ready = word_ready_q;
    assign cfg_en          = cfg_en_q;
    assign cfg_sdo         = cfg_en_q & sreg_bit;
    assign busy            = busy_q;
    assign done            = done_q;
    assign bits_left       = bits_left_q;

endmodule
